// File: rtl/mem_bus_pkg.sv
// Shared types for the tri-state memory bus initiator: transfer sizes,
// FSM states and the registered bus-control bundle.
package mem_bus_pkg;

  localparam int BUS_WIDTH = 32;

  typedef enum logic [1:0] {
    SIZE_BYTE   = 2'h0,
    SIZE_HALF,
    SIZE_WORD,
    SIZE_DOUBLE
  } mem_size_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ADDR,
    ST_RD_TURN,
    ST_RD_CAP,
    ST_WR_DATA,
    ST_WR_GAP,
    ST_WR_ADDR,
    ST_WR_DONE
  } mem_bus_state_t;

  typedef struct packed {
    logic drive_en;
    logic read_write;
    logic data_address;
    logic input_enable;
    logic output_enable;
  } bus_ctrl_t;

  localparam bus_ctrl_t CTRL_OFF = '0;

  // The watchdog only runs while the master waits for the memory's handshake.
  function automatic logic is_addr_state(input mem_bus_state_t s);
    return (s == ST_RD_ADDR) || (s == ST_WR_ADDR);
  endfunction

endpackage

// File: rtl/mem_bus_watchdog.sv
// Wait-state watchdog: counts cycles spent in an address phase and flags the
// first cycle (handshake not yet trustworthy) and the final allowed cycle.
module mem_bus_watchdog #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic first,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && !expired) begin
      count_reg <= count_reg + CW'(1);
    end
  end

  assign first   = (count_reg == '0);
  assign expired = (count_reg == LAST);

endmodule

// File: rtl/mem_bus_master.sv
// Bus initiator: turns one core load/store into the memory's tri-state
// handshake, owning bus direction with a turnaround cycle before reads return.
module mem_bus_master
  import mem_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [BUS_WIDTH-1:0] req_addr,
  input  logic [BUS_WIDTH-1:0] req_wdata,
  input  logic [1:0]           req_size,
  input  logic                 req_sign,
  output logic                 resp_valid,
  output logic [BUS_WIDTH-1:0] resp_rdata,
  output logic                 resp_err,
  inout  wire  [BUS_WIDTH-1:0] bus,
  output logic                 read_write,
  output logic                 data_address,
  output logic                 input_enable,
  output logic                 output_enable,
  output logic [1:0]           size,
  output logic                 sign,
  input  logic                 done_or_valid
);

  mem_bus_state_t       state_reg, state_next;
  bus_ctrl_t            ctrl_reg, ctrl_next;
  logic [BUS_WIDTH-1:0] bus_reg, bus_next;
  logic [BUS_WIDTH-1:0] addr_reg, addr_next;
  mem_size_t            size_reg, size_next;
  logic                 sign_reg, sign_next;
  logic [BUS_WIDTH-1:0] rdata_reg, rdata_next;
  logic                 valid_reg, valid_next;
  logic                 err_reg, err_next;
  logic                 ready_reg, ready_next;
  logic                 wd_first, wd_expired;
  logic                 drive_en;

  mem_bus_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clock   (clock),
    .reset   (reset),
    .clear   (!is_addr_state(state_reg)),
    .enable  (is_addr_state(state_reg)),
    .first   (wd_first),
    .expired (wd_expired)
  );

  always_comb begin
    state_next = state_reg;
    ctrl_next  = ctrl_reg;
    bus_next   = bus_reg;
    addr_next  = addr_reg;
    size_next  = size_reg;
    sign_next  = sign_reg;
    rdata_next = rdata_reg;
    valid_next = 1'b0;
    err_next   = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        if (req_valid && ready_reg) begin
          addr_next                = req_addr;
          size_next                = mem_size_t'(req_size);
          sign_next                = req_sign;
          ctrl_next                = CTRL_OFF;
          ctrl_next.drive_en       = 1'b1;
          ctrl_next.input_enable   = 1'b1;
          if (req_write) begin
            state_next             = ST_WR_DATA;
            bus_next               = req_wdata;
            ctrl_next.read_write   = 1'b1;
          end else begin
            state_next             = ST_RD_ADDR;
            bus_next               = req_addr;
            ctrl_next.data_address = 1'b1;
          end
        end
      end
      ST_RD_ADDR, ST_WR_ADDR: begin
        // done seen on the first address cycle may be stale, so it is ignored there
        if (done_or_valid && !wd_first) begin
          ctrl_next = CTRL_OFF;
          if (state_reg == ST_RD_ADDR) begin
            state_next              = ST_RD_TURN;
            ctrl_next.output_enable = 1'b1;
          end else begin
            state_next = ST_WR_DONE;
            valid_next = 1'b1;
            rdata_next = '0;
          end
        end else if (wd_expired) begin
          state_next = ST_IDLE;
          ctrl_next  = CTRL_OFF;
          valid_next = 1'b1;
          err_next   = 1'b1;
          rdata_next = '0;
        end
      end
      ST_RD_TURN: begin
        state_next = ST_RD_CAP;
        ctrl_next  = CTRL_OFF;
        rdata_next = bus;
        valid_next = 1'b1;
      end
      ST_WR_DATA: begin
        state_next             = ST_WR_GAP;
        ctrl_next.input_enable = 1'b0;
      end
      ST_WR_GAP: begin
        state_next             = ST_WR_ADDR;
        bus_next               = addr_reg;
        ctrl_next.data_address = 1'b1;
        ctrl_next.input_enable = 1'b1;
      end
      ST_RD_CAP, ST_WR_DONE: begin
        state_next = ST_IDLE;
        ctrl_next  = CTRL_OFF;
      end
      default: begin
        state_next = ST_IDLE;
        ctrl_next  = CTRL_OFF;
      end
    endcase
    // The response cycle itself never accepts, so back-to-back requests see one gap.
    ready_next = (state_next == ST_IDLE) && !valid_next;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      ctrl_reg  <= CTRL_OFF;
      bus_reg   <= '0;
      addr_reg  <= '0;
      size_reg  <= SIZE_BYTE;
      sign_reg  <= 1'b0;
      rdata_reg <= '0;
      valid_reg <= 1'b0;
      err_reg   <= 1'b0;
      ready_reg <= 1'b1;
    end else begin
      state_reg <= state_next;
      ctrl_reg  <= ctrl_next;
      bus_reg   <= bus_next;
      addr_reg  <= addr_next;
      size_reg  <= size_next;
      sign_reg  <= sign_next;
      rdata_reg <= rdata_next;
      valid_reg <= valid_next;
      err_reg   <= err_next;
      ready_reg <= ready_next;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      assert (!(drive_en && output_enable));
    end
  end

  assign drive_en      = ctrl_reg.drive_en;
  assign bus           = drive_en ? bus_reg : {BUS_WIDTH{1'bz}};
  assign read_write    = ctrl_reg.read_write;
  assign data_address  = ctrl_reg.data_address;
  assign input_enable  = ctrl_reg.input_enable;
  assign output_enable = ctrl_reg.output_enable;
  assign size          = size_reg;
  assign sign          = sign_reg;
  assign req_ready     = ready_reg;
  assign resp_valid    = valid_reg;
  assign resp_rdata    = rdata_reg;
  assign resp_err      = err_reg;

endmodule

// File: tb/tb_mem_bus_master.sv
// Directed and random checks of mem_bus_master paired with a behavioural
// memory responder and an independent byte-array reference model.
module tb_mem_bus_master;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [1:0]  req_size = '0;
  logic        req_sign = 1'b0;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        read_write, data_address, input_enable, output_enable, sign;
  logic [1:0]  size;
  logic        done_or_valid = 1'b0;
  wire  [31:0] bus;

  int vectors = 0;
  int miscompares = 0;
  int contention = 0;

  always #5 clock = ~clock;

  mem_bus_master #(.TIMEOUT_CYCLES(16)) dut (
    .clock         (clock),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_write     (req_write),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_size      (req_size),
    .req_sign      (req_sign),
    .resp_valid    (resp_valid),
    .resp_rdata    (resp_rdata),
    .resp_err      (resp_err),
    .bus           (bus),
    .read_write    (read_write),
    .data_address  (data_address),
    .input_enable  (input_enable),
    .output_enable (output_enable),
    .size          (size),
    .sign          (sign),
    .done_or_valid (done_or_valid)
  );

  // Memory responder: samples on negedge, done after (1 + wait_states) cycles.
  logic [7:0]  mem   [0:1023];
  logic [7:0]  model [0:1023];
  logic [31:0] mem_rdata = '0;
  logic [31:0] mem_wdata = '0;
  logic        ie_prev = 1'b0;
  int          ws_cnt = 0;
  int          wait_states = 0;
  bit          mute = 1'b0;

  assign bus = output_enable ? mem_rdata : 32'hzzzz_zzzz;

  function automatic logic [31:0] extend(input logic [31:0] raw, input logic [1:0] sz, input logic sg);
    case (sz)
      2'd0:    return sg ? {{24{raw[7]}}, raw[7:0]} : {24'h0, raw[7:0]};
      2'd1:    return sg ? {{16{raw[15]}}, raw[15:0]} : {16'h0, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  always @(negedge clock) begin : responder
    int a;
    if (input_enable && !ie_prev) begin
      done_or_valid <= 1'b0;
      ws_cnt        <= 1 + wait_states;
      if (data_address) begin
        a = int'(bus[9:0]);
        if (!read_write)
          mem_rdata <= extend({mem[(a+3)%1024], mem[(a+2)%1024], mem[(a+1)%1024], mem[a]}, size, sign);
        else
          for (int i = 0; i < nbytes(size); i++) mem[(a+i)%1024] <= mem_wdata[8*i +: 8];
      end else begin
        mem_wdata <= bus;
      end
    end else if (input_enable && ws_cnt > 0) begin
      ws_cnt <= ws_cnt - 1;
      if (ws_cnt == 1 && !mute) done_or_valid <= 1'b1;
    end
    ie_prev <= input_enable;
  end

  always @(posedge clock) begin
    if (dut.drive_en && output_enable) contention++;
  end

  function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [1:0] sz, input logic sg);
    int a;
    a = int'(addr[9:0]);
    return extend({model[(a+3)%1024], model[(a+2)%1024], model[(a+1)%1024], model[a]}, sz, sg);
  endfunction

  task automatic model_store(input logic [31:0] addr, input logic [31:0] wdata, input logic [1:0] sz);
    int a;
    a = int'(addr[9:0]);
    for (int i = 0; i < nbytes(sz); i++) model[(a+i)%1024] = wdata[8*i +: 8];
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Latency counts the accept cycle as 0; resp_valid is seen in cycle 'lat'.
  task automatic xact(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [1:0] sz, input logic sg,
                      output logic [31:0] rdata, output logic err, output int lat);
    int n;
    @(negedge clock);
    req_valid = 1'b1; req_write = wr; req_addr = addr;
    req_wdata = wdata; req_size = sz; req_sign = sg;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clock); n++; end
    if (!req_ready) begin
      check("accept_wait", {31'b0, req_ready}, 32'd1);
      req_valid = 1'b0; rdata = 'x; err = 1'bx; lat = -1;
      return;
    end
    @(posedge clock); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 40) begin @(posedge clock); #1; lat++; end
    if (!resp_valid) check("resp_wait", {31'b0, resp_valid}, 32'd1);
    rdata = resp_rdata;
    err   = resp_err;
    if (wr) model_store(addr, wdata, sz);
    $display("xact %s addr=%h size=%0d sign=%0d wdata=%h -> rdata=%h err=%0d lat=%0d",
             wr ? "ST" : "LD", addr, sz, sg, wdata, rdata, err, lat);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    logic [31:0] rd, exp;
    logic        er, wr, sg;
    logic [31:0] ad, wd;
    logic [1:0]  sz;
    int          lat, n;
    bit          seen;

    for (int i = 0; i < 1024; i++) begin
      mem[i]   = 8'($urandom);
      model[i] = mem[i];
    end
    mem[0] = 8'h93; mem[1] = 8'h00; mem[2] = 8'h00; mem[3] = 8'h00; mem[24] = 8'h23;
    model[0] = 8'h93; model[1] = 8'h00; model[2] = 8'h00; model[3] = 8'h00; model[24] = 8'h23;

    // Reset state
    #12;
    check("rst_ctrl", {23'b0, read_write, data_address, input_enable, output_enable,
                       dut.drive_en, resp_valid, resp_err, sign, size}, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    @(negedge clock); reset = 1'b1;
    @(negedge clock);
    check("rst_ready", {31'b0, req_ready}, 32'd1);

    // Word load, zero wait states
    xact(1'b0, 32'h0, 32'h0, 2'd2, 1'b0, rd, er, lat);
    check("ld_word_data", rd, 32'h0000_0093);
    check("ld_word_lat", 32'(lat), 32'd4);
    check("ld_word_err", {31'b0, er}, 32'd0);
    @(posedge clock); #1;
    check("b2b_ready", {30'b0, req_ready, resp_valid}, 32'b10);

    xact(1'b0, 32'h18, 32'h0, 2'd0, 1'b1, rd, er, lat);
    check("ld_byte_pos", rd, 32'h0000_0023);

    xact(1'b1, 32'h100, 32'h0000_0080, 2'd0, 1'b0, rd, er, lat);
    check("st_byte_rdata", rd, 32'd0);
    check("st_byte_lat", 32'(lat), 32'd5);
    xact(1'b0, 32'h100, 32'h0, 2'd0, 1'b1, rd, er, lat);
    check("ld_byte_sext", rd, 32'hFFFF_FF80);
    xact(1'b0, 32'h100, 32'h0, 2'd0, 1'b0, rd, er, lat);
    check("ld_byte_zext", rd, 32'h0000_0080);

    xact(1'b1, 32'h200, 32'hDEAD_BEEF, 2'd2, 1'b0, rd, er, lat);
    check("st_word_rdata", rd, 32'd0);
    xact(1'b0, 32'h202, 32'h0, 2'd1, 1'b0, rd, er, lat);
    check("ld_half_hi", rd, 32'h0000_DEAD);
    xact(1'b0, 32'h200, 32'h0, 2'd1, 1'b1, rd, er, lat);
    check("ld_half_sext", rd, 32'hFFFF_BEEF);

    // Two wait states stretch the address phase
    wait_states = 2;
    xact(1'b0, 32'h200, 32'h0, 2'd3, 1'b0, rd, er, lat);
    check("ld_ws_data", rd, 32'hDEAD_BEEF);
    check("ld_ws_lat", 32'(lat), 32'd6);
    wait_states = 0;

    // Timeout: 16 cycles in RD_ADDR, aborted response in the following cycle
    mute = 1'b1;
    xact(1'b0, 32'h0, 32'h0, 2'd2, 1'b0, rd, er, lat);
    check("to_err", {31'b0, er}, 32'd1);
    check("to_rdata", rd, 32'd0);
    check("to_lat", 32'(lat), 32'd17);
    check("to_ctrl", {27'b0, read_write, data_address, input_enable, output_enable, dut.drive_en}, 32'd0);
    mute = 1'b0;
    xact(1'b0, 32'h18, 32'h0, 2'd0, 1'b0, rd, er, lat);
    check("post_to_ld", {er, rd[30:0]}, 32'h0000_0023);

    // Reset during RD_TURN
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0; req_size = 2'd2; req_sign = 1'b0;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clock); n++; end
    @(posedge clock); #1;
    req_valid = 1'b0;
    n = 0;
    while (!output_enable && n < 20) begin @(posedge clock); #1; n++; end
    check("turn_reached", {31'b0, output_enable}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("midrst_ctrl", {26'b0, read_write, data_address, input_enable, output_enable,
                          dut.drive_en, resp_valid}, 32'd0);
    @(negedge clock); reset = 1'b1;
    seen = 1'b0;
    repeat (6) begin @(posedge clock); #1; if (resp_valid) seen = 1'b1; end
    check("midrst_no_resp", {31'b0, seen}, 32'd0);
    xact(1'b0, 32'h0, 32'h0, 2'd2, 1'b0, rd, er, lat);
    check("midrst_next_ld", rd, 32'h0000_0093);

    // Random back-to-back traffic against the byte model
    for (int t = 0; t < 1000; t++) begin
      wr = 1'($urandom_range(0, 1));
      ad = 32'($urandom_range(0, 1023));
      wd = $urandom;
      sz = 2'($urandom_range(0, 3));
      sg = 1'($urandom_range(0, 1));
      exp = wr ? 32'd0 : model_load(ad, sz, sg);
      xact(wr, ad, wd, sz, sg, rd, er, lat);
      check("rnd_rdata", rd, exp);
      check("rnd_err", {31'b0, er}, 32'd0);
      check("rnd_lat", 32'(lat), wr ? 32'd5 : 32'd4);
    end

    check("contention", 32'(contention), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
